// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the regfile read port in ascending order and streams each register as a valid/ready beat.
// Optional REGFILE_DUMP_CHECKSUM_EN appends one XOR-checksum beat after the last register.
module regfile_dump #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_q;
    logic                last_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
`endif

    // idx_q is itself a register, so the read address is registered without a second copy
    assign rf_read_addr = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dump_valid   = valid_q;
    assign dump_data    = data_q;
    assign dump_addr    = addr_q;
    assign dump_last    = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        idx_q   <= FIRST_IDX;
                        busy_q  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    data_q  <= rf_read_data;
                    addr_q  <= idx_q;
                    valid_q <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    last_q  <= 1'b0;
`else
                    last_q  <= (idx_q == LAST_IDX);
`endif
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (valid_q && dump_ready) begin
                        valid_q <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum_q  <= csum_q ^ data_q;
`endif
                        if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // Checksum beat is loaded on the same edge the last register beat retires
                            state_q <= S_CSUM;
                            valid_q <= 1'b1;
                            data_q  <= csum_q ^ data_q;
                            addr_q  <= '0;
                            last_q  <= 1'b1;
`else
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= S_FETCH;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (valid_q && dump_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (FIRST_REG 0 and 1) against a beat-list model of the regfile.
module tb_regfile_dump;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [1:0]           start;
    logic [1:0]           rdy;
    wire  [1:0]           busy, done, dv, dl;
    wire  [1:0][AW-1:0]   rfa, da;
    wire  [1:0][DW-1:0]   rfd, dd;
    logic [DW-1:0]        regs [NR];

    assign rfd[0] = regs[rfa[0]];
    assign rfd[1] = regs[rfa[1]];

    regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rf_read_addr(rfa[0]), .rf_read_data(rfd[0]), .dump_valid(dv[0]), .dump_ready(rdy[0]),
        .dump_data(dd[0]), .dump_addr(da[0]), .dump_last(dl[0]));

    regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rf_read_addr(rfa[1]), .rf_read_data(rfd[1]), .dump_valid(dv[1]), .dump_ready(rdy[1]),
        .dump_data(dd[1]), .dump_addr(da[1]), .dump_last(dl[1]));

    // Sink-side monitor, sampled mid-cycle: records accepted beats, hold violations, busy/done timing
    logic [37:0] got [2][512];
    int          nbeat [2]    = '{0, 0};
    int          stab_err [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          busy_cyc [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic        hold [2]     = '{1'b0, 1'b0};
    logic [37:0] hval [2];
    logic        bprev [2]    = '{1'b0, 1'b0};
    int          cyc          = 0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                hold[i]  = 1'b0;
                bprev[i] = 1'b0;
            end else begin
                if (hold[i] && (!dv[i] || {dl[i], da[i], dd[i]} != hval[i])) stab_err[i]++;
                hold[i] = dv[i] && !rdy[i];
                hval[i] = {dl[i], da[i], dd[i]};
                if (dv[i] && rdy[i]) begin
                    if (nbeat[i] < 512) got[i][nbeat[i]] = {dl[i], da[i], dd[i]};
                    nbeat[i]++;
                end
                if (busy[i] && !bprev[i]) busy_cyc[i] = cyc;
                bprev[i] = busy[i];
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
            end
        end
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready held, 1 ready 1-of-3, 2 random ready; inj bit0: start at beat 10, bit1: start in DONE
    task automatic run_dump(input int i, input int mode, input int inj, input bit timed, input string tag);
        logic [37:0] exp [$];
        logic [31:0] x;
        int base, dbase, sbase;
        bit pulsed, fin;
        x = '0;
        for (int a = i; a < NR; a++) begin
            exp.push_back({1'((a == NR - 1) && !CS), 5'(a), regs[a]});
            x ^= regs[a];
        end
        if (CS) exp.push_back({1'b1, 5'd0, x});
        base  = nbeat[i];
        dbase = done_cnt[i];
        sbase = stab_err[i];
        @(posedge clk); #1;
        start[i] = 1'b1;
        rdy[i]   = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        fin = 1'b0;
        pulsed = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            case (mode)
                0:       rdy[i] = 1'b1;
                1:       rdy[i] = 1'((c % 3) == 2);
                default: rdy[i] = 1'($urandom_range(0, 1));
            endcase
            if ((inj & 1) != 0 && !pulsed && (nbeat[i] - base) == 10) begin
                start[i] = 1'b1;
                pulsed   = 1'b1;
            end
            @(posedge clk); #1;
            start[i] = 1'b0;
            if (done[i]) begin
                fin = 1'b1;
                if ((inj & 2) != 0) start[i] = 1'b1;
                rdy[i] = 1'b1;
                @(posedge clk); #1;
                start[i] = 1'b0;
            end
        end
        chk({tag, " done reached"}, 64'(fin), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, " beat count"}, 64'(nbeat[i] - base), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < nbeat[i] - base; k++)
            chk($sformatf("%s beat %0d {last,addr,data}", tag, k), 64'(got[i][base + k]), 64'(exp[k]));
        chk({tag, " done pulses"}, 64'(done_cnt[i] - dbase), 64'd1);
        chk({tag, " busy low after"}, 64'(busy[i]), 64'd0);
        chk({tag, " hold stability"}, 64'(stab_err[i] - sbase), 64'd0);
        if (timed)
            chk({tag, " busy-to-done cycles"}, 64'(done_cyc[i] - busy_cyc[i]),
                64'(2 * (NR - i) + (CS ? 1 : 0)));
    endtask

    initial begin
        bit stalled;
        rst_n = 1'b0;
        start = '0;
        rdy   = '0;
        for (int a = 0; a < NR; a++) regs[a] = (a == 0) ? 32'd0 : 32'(a + 100);
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset outs inst%0d {busy,done,valid,last}", i),
                64'({busy[i], done[i], dv[i], dl[i]}), 64'd0);
            chk($sformatf("reset data/addr inst%0d", i), 64'({da[i], dd[i]}), 64'd0);
            chk($sformatf("reset rf addr inst%0d", i), 64'(rfa[i]), 64'(i));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_dump(0, 0, 0, 1'b1, "T1 full dump");
        run_dump(0, 1, 0, 1'b0, "T2 backpressure");
        run_dump(0, 0, 3, 1'b1, "T3 start while busy/done");

        // Stall on addr 17 then reset asynchronously mid-cycle
        @(posedge clk); #1;
        start[0] = 1'b1;
        rdy[0]   = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        stalled  = 1'b0;
        for (int c = 0; c < 500 && !stalled; c++) begin
            @(posedge clk); #1;
            if (dv[0] && da[0] == 5'd17) begin
                rdy[0]  = 1'b0;
                stalled = 1'b1;
            end
        end
        chk("T4 stall on addr 17", 64'(stalled), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("T4 async reset {valid,busy,done}", 64'({dv[0], busy[0], done[0]}), 64'd0);
        chk("T4 async reset rf addr", 64'(rfa[0]), 64'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rdy[0] = 1'b1;
        run_dump(0, 0, 0, 1'b1, "T4 restart");

        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NR; a++) regs[a] = $urandom;
            run_dump(0, 2, 0, 1'b0, $sformatf("R%0d random", r));
        end

        for (int a = 0; a < NR; a++) regs[a] = (a == 0) ? 32'd0 : 32'(a + 100);
        run_dump(1, 0, 0, 1'b1, "T6 first_reg=1");
        for (int a = 0; a < NR; a++) regs[a] = $urandom;
        run_dump(1, 2, 0, 1'b0, "T6 first_reg=1 random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
